// File: rtl/vs_mod_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vs_mod_counter : modulo up/down counter with load, clear, wrap/saturate   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module vs_mod_counter #(
  parameter int     N         = 16,
  parameter longint MAX_VALUE = (longint'(1) << N) - 1,
  parameter int     SATURATE  = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         down,
  input  logic         clear,
  input  logic         load,
  input  logic [N-1:0] load_value,
  output logic [N-1:0] out,
  output logic         at_max,
  output logic         at_min,
  output logic         wrap,
  output logic         tc
);

  if (N < 1 || N > 62 || MAX_VALUE < 1 || MAX_VALUE > ((longint'(1) << N) - 1)) begin : g_bad_max
    $error("vs_mod_counter: MAX_VALUE out of range for width N");
  end

  localparam logic [N-1:0] c_max  = MAX_VALUE[N-1:0];
  localparam logic [N-1:0] c_zero = '0;
  localparam logic [N-1:0] c_one  = {{(N-1){1'b0}}, 1'b1};
  localparam bit           c_sat  = (SATURATE != 0);

  logic [N-1:0] out_q, out_d;
  logic         wrap_q, wrap_d;

  assign at_max = (out_q == c_max);
  assign at_min = (out_q == c_zero);

  always_comb begin
    out_d  = out_q;
    wrap_d = 1'b0;
    if (clear) begin
      out_d = c_zero;
    end else if (load) begin
      out_d = (load_value > c_max) ? c_max : load_value;
    end else if (enable) begin
      // The limit is compared explicitly so a non power-of-two modulus wraps correctly.
      if (!down) begin
        if (!at_max) begin
          out_d = out_q + c_one;
        end else if (!c_sat) begin
          out_d  = c_zero;
          wrap_d = 1'b1;
        end
      end else begin
        if (!at_min) begin
          out_d = out_q - c_one;
        end else if (!c_sat) begin
          out_d  = c_max;
          wrap_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q  <= c_zero;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = out_q;
  assign wrap = wrap_q;
  assign tc   = enable & ((~down & at_max) | (down & at_min));

endmodule
`default_nettype wire

// File: tb/tb_vs_mod_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vs_mod_counter : vector table, hand sequences and random model check   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_vs_mod_counter;

  logic        clk = 1'b0;
  logic        reset, enable, down, clear, load;
  logic [15:0] lv;

  logic [3:0]  out_a, out_b, out_d;
  logic [15:0] out_c;
  logic [3:0]  wrap_v, atmax_v, atmin_v, tc_v;

  always #5 clk = ~clk;

  // a: N=4 mod 10 wrap, b: N=4 mod 10 saturate, c: 16-bit defaults, d: modulus 2
  vs_mod_counter #(.N(4), .MAX_VALUE(9), .SATURATE(0)) dut_a (
    .clock(clk), .reset(reset), .enable(enable), .down(down), .clear(clear), .load(load),
    .load_value(lv[3:0]), .out(out_a), .at_max(atmax_v[0]), .at_min(atmin_v[0]),
    .wrap(wrap_v[0]), .tc(tc_v[0]));
  vs_mod_counter #(.N(4), .MAX_VALUE(9), .SATURATE(1)) dut_b (
    .clock(clk), .reset(reset), .enable(enable), .down(down), .clear(clear), .load(load),
    .load_value(lv[3:0]), .out(out_b), .at_max(atmax_v[1]), .at_min(atmin_v[1]),
    .wrap(wrap_v[1]), .tc(tc_v[1]));
  vs_mod_counter #(.N(16)) dut_c (
    .clock(clk), .reset(reset), .enable(enable), .down(down), .clear(clear), .load(load),
    .load_value(lv), .out(out_c), .at_max(atmax_v[2]), .at_min(atmin_v[2]),
    .wrap(wrap_v[2]), .tc(tc_v[2]));
  vs_mod_counter #(.N(4), .MAX_VALUE(1), .SATURATE(0)) dut_d (
    .clock(clk), .reset(reset), .enable(enable), .down(down), .clear(clear), .load(load),
    .load_value(lv[3:0]), .out(out_d), .at_max(atmax_v[3]), .at_min(atmin_v[3]),
    .wrap(wrap_v[3]), .tc(tc_v[3]));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain integer count per instance.
  int mmax [4] = '{9, 9, 65535, 1};
  int mmask[4] = '{15, 15, 65535, 15};
  bit msat [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  int mcnt [4];
  bit mwr  [4];
  bit mvalid = 1'b0;

  typedef struct {
    bit          rst, clr, ld, en, dn;
    logic [15:0] lv;
    int          eo;
    bit          ew;
    bit          etc;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] get_out(input int i);
    case (i)
      0:       return 32'(out_a);
      1:       return 32'(out_b);
      2:       return 32'(out_c);
      default: return 32'(out_d);
    endcase
  endfunction

  task automatic step();
    bit etc;
    int lvm;
    #1;
    if (mvalid) begin
      for (int i = 0; i < 4; i++) begin
        etc = enable && ((!down && mcnt[i] == mmax[i]) || (down && mcnt[i] == 0));
        check($sformatf("tc[%0d]", i), 32'(tc_v[i]), 32'(etc));
      end
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      lvm = int'(lv) & mmask[i];
      mwr[i] = 1'b0;
      if (reset || clear) mcnt[i] = 0;
      else if (load) mcnt[i] = (lvm > mmax[i]) ? mmax[i] : lvm;
      else if (enable) begin
        if (!down) begin
          if (mcnt[i] < mmax[i]) mcnt[i]++;
          else if (!msat[i]) begin mcnt[i] = 0; mwr[i] = 1'b1; end
        end else begin
          if (mcnt[i] > 0) mcnt[i]--;
          else if (!msat[i]) begin mcnt[i] = mmax[i]; mwr[i] = 1'b1; end
        end
      end
    end
    if (reset) mvalid = 1'b1;
    #1;
    if (mvalid) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("out[%0d]", i), get_out(i), 32'(mcnt[i]));
        check($sformatf("wrap[%0d]", i), 32'(wrap_v[i]), 32'(mwr[i]));
        check($sformatf("at_max[%0d]", i), 32'(atmax_v[i]), 32'(mcnt[i] == mmax[i]));
        check($sformatf("at_min[%0d]", i), 32'(atmin_v[i]), 32'(mcnt[i] == 0));
      end
    end
  endtask

  task automatic run(input bit r, input bit c, input bit l, input bit e, input bit d,
                     input logic [15:0] v);
    reset = r; clear = c; load = l; enable = e; down = d; lv = v;
    step();
  endtask

  function automatic void add(input bit r, input bit c, input bit l, input bit e, input bit d,
                              input logic [15:0] v, input int eo, input bit ew, input bit etc);
    vec_t t;
    t.rst = r; t.clr = c; t.ld = l; t.en = e; t.dn = d; t.lv = v;
    t.eo = eo; t.ew = ew; t.etc = etc;
    tbl.push_back(t);
  endfunction

  initial begin
    int exp4[4];
    // Table for instance a (mod 10, wrap); etc = tc seen before the edge.
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) add(0, 0, 0, 1, 0, 0, k, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 2, 2, 0, 0);
    add(0, 0, 0, 1, 1, 0, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 9, 1, 1);
    add(0, 0, 0, 1, 1, 0, 8, 0, 0);
    add(0, 0, 1, 0, 0, 15, 9, 0, 0);
    add(0, 0, 1, 1, 0, 3, 3, 0, 1);
    add(0, 1, 1, 1, 0, 5, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 0, 0);
    add(1, 0, 1, 1, 0, 7, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 0, 0);

    run(1, 0, 0, 0, 0, 16'h1234);
    run(1, 0, 0, 0, 0, 0);
    check("reset out", 32'(out_a), 32'd0);
    check("reset wrap", 32'(wrap_v[0]), 32'd0);
    check("reset at_min", 32'(atmin_v[0]), 32'd1);
    check("reset at_max", 32'(atmax_v[0]), 32'd0);
    check("reset tc", 32'(tc_v[0]), 32'd0);

    foreach (tbl[k]) begin
      reset = tbl[k].rst; clear = tbl[k].clr; load = tbl[k].ld;
      enable = tbl[k].en; down = tbl[k].dn; lv = tbl[k].lv;
      #1;
      check($sformatf("vec%0d tc", k), 32'(tc_v[0]), 32'(tbl[k].etc));
      step();
      check($sformatf("vec%0d out", k), 32'(out_a), 32'(tbl[k].eo));
      check($sformatf("vec%0d wrap", k), 32'(wrap_v[0]), 32'(tbl[k].ew));
    end

    // Saturation on b.
    run(0, 0, 1, 0, 0, 7);
    exp4 = '{8, 9, 9, 9};
    for (int k = 0; k < 5; k++) begin
      run(0, 0, 0, 1, 0, 0);
      check($sformatf("sat up %0d", k), 32'(out_b), (k == 0) ? 32'd8 : 32'd9);
      check($sformatf("sat up wrap %0d", k), 32'(wrap_v[1]), 32'd0);
      check($sformatf("sat up tc %0d", k), 32'(tc_v[1]), (k == 0) ? 32'd0 : 32'd1);
    end
    run(0, 0, 1, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      run(0, 0, 0, 1, 1, 0);
      check($sformatf("sat dn %0d", k), 32'(out_b), 32'd0);
      check($sformatf("sat dn wrap %0d", k), 32'(wrap_v[1]), 32'd0);
      check($sformatf("sat dn at_min %0d", k), 32'(atmin_v[1]), 32'd1);
    end

    // Hold, mid-run reset and full-width wrap on c.
    run(0, 0, 1, 0, 0, 16'd100);
    for (int k = 0; k < 3; k++) begin
      run(0, 0, 0, 0, 0, 16'hFFFF);
      check($sformatf("hold %0d", k), 32'(out_c), 32'd100);
    end
    run(0, 0, 1, 0, 0, 16'hFFFE);
    run(1, 0, 0, 1, 0, 0);
    check("mid reset", 32'(out_c), 32'd0);
    run(0, 0, 1, 0, 0, 16'hFFFD);
    run(0, 0, 0, 1, 0, 0);
    run(0, 0, 0, 1, 0, 0);
    check("c at ffff", 32'(out_c), 32'hFFFF);
    run(0, 0, 0, 1, 0, 0);
    check("c wrap out", 32'(out_c), 32'd0);
    check("c wrap pulse", 32'(wrap_v[2]), 32'd1);

    // Modulus 2 on d: back-to-back wraps.
    run(1, 0, 0, 0, 0, 0);
    exp4 = '{1, 0, 1, 0};
    for (int k = 0; k < 4; k++) begin
      run(0, 0, 0, 1, 0, 0);
      check($sformatf("mod2 out %0d", k), 32'(out_d), 32'(exp4[k]));
      check($sformatf("mod2 wrap %0d", k), 32'(wrap_v[3]), 32'(exp4[k] == 0));
    end

    // Random stimulus against the model on all four instances.
    for (int k = 0; k < 500; k++) begin
      run(($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
